// File: rtl/dm_hart_bridge.sv
// dm_hart_bridge: debug-module core joining DMI to a hart's debug bus window.
// Define DM_PROGBUF_INIT_EN to reset progbuf to nops ending in ebreak.
module dm_hart_bridge #(
  parameter int DMI_ABITS = 7,
  parameter int NDATA = 2,
  parameter int PROGBUF = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 dmi_valid,
  output logic                 dmi_ready,
  input  logic                 dmi_write,
  input  logic [DMI_ABITS-1:0] dmi_addr,
  input  logic [31:0]          dmi_wdata,
  output logic [31:0]          dmi_rdata,
  input  logic                 bus_valid,
  output logic                 bus_ready,
  input  logic                 bus_write,
  input  logic [17:0]          bus_addr,
  input  logic [31:0]          bus_wdata,
  output logic [31:0]          bus_rdata,
  output logic                 debug_req
);
  typedef enum logic [1:0] {RUNNING, HALTING, HALTED, RESUMING} state_e;
  state_e state_q, state_d;
  logic dmi_ready_q, dmi_ready_d, bus_ready_q, bus_ready_d;
  logic dmactive_q, dmactive_d, ack_q, ack_d;
  logic [31:0] dmi_rdata_q, dmi_rdata_d, bus_rdata_q, bus_rdata_d;
  logic [31:0] data_q [NDATA];
  logic [31:0] data_d [NDATA];
  logic [31:0] progbuf_q [PROGBUF];
  logic [31:0] progbuf_d [PROGBUF];
  logic [31:0] da, ba, dmstatus, dmi_rd, bus_rd;
  logic dmi_we, bus_we, halt, resume;
  always_comb begin
    da = 32'(dmi_addr);
    ba = 32'(bus_addr);
    // resetn gating keeps a transfer caught by reset from landing in progbuf
    dmi_we = resetn && dmi_valid && dmi_ready_q && dmi_write;
    bus_we = resetn && bus_valid && bus_ready_q && bus_write;
    dmi_ready_d = dmi_valid && !dmi_ready_q;
    bus_ready_d = bus_valid && !bus_ready_q;
    dmstatus = {14'b0, ack_q, 5'b0, state_q == RUNNING, 1'b0, state_q == HALTED, 5'b0, 4'd2};
    dmi_rd = '0;
    bus_rd = '0;
    for (int i = 0; i < NDATA; i++) begin
      if (da == 32'(4 + i)) dmi_rd = data_q[i];
      if (ba == 32'(64 + i)) bus_rd = data_q[i];
    end
    for (int j = 0; j < PROGBUF; j++) begin
      if (da == 32'(32 + j)) dmi_rd = progbuf_q[j];
      if (ba == 32'(j)) bus_rd = progbuf_q[j];
    end
    if (da == 32'h10) dmi_rd = {31'b0, dmactive_q};
    if (da == 32'h11) dmi_rd = dmstatus;
    if (ba == 32'h81) bus_rd = {31'b0, state_q == RESUMING};
    dmi_rdata_d = (dmi_ready_d && !dmi_write) ? dmi_rd : dmi_rdata_q;
    bus_rdata_d = (bus_ready_d && !bus_write) ? bus_rd : bus_rdata_q;
    data_d = data_q;
    progbuf_d = progbuf_q;
    // DMI assignment comes last so it wins a same-word collision
    for (int i = 0; i < NDATA; i++) begin
      if (bus_we && ba == 32'(64 + i)) data_d[i] = bus_wdata;
      if (dmi_we && da == 32'(4 + i)) data_d[i] = dmi_wdata;
    end
    for (int j = 0; j < PROGBUF; j++) begin
      if (bus_we && ba == 32'(j)) progbuf_d[j] = bus_wdata;
      if (dmi_we && da == 32'(32 + j)) progbuf_d[j] = dmi_wdata;
    end
    dmactive_d = (dmi_we && da == 32'h10) ? dmi_wdata[0] : dmactive_q;
    halt = dmi_we && da == 32'h10 && dmi_wdata[31] && dmactive_d;
    resume = dmi_we && da == 32'h10 && dmi_wdata[30] && dmactive_d;
    state_d = state_q;
    ack_d = ack_q;
    if (state_q == RUNNING && halt) state_d = HALTING;
    if (state_q == HALTING && bus_we && ba == 32'h80) state_d = HALTED;
    if (state_q == HALTED && resume) begin
      state_d = RESUMING;
      ack_d = 1'b0;
    end
    if (state_q == RESUMING && bus_we && ba == 32'h82) begin
      state_d = RUNNING;
      ack_d = 1'b1;
    end
    if (!dmactive_d) state_d = RUNNING;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= RUNNING;
      dmi_ready_q <= 1'b0;
      bus_ready_q <= 1'b0;
      dmi_rdata_q <= '0;
      bus_rdata_q <= '0;
      dmactive_q <= 1'b0;
      ack_q <= 1'b0;
      data_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      dmi_ready_q <= dmi_ready_d;
      bus_ready_q <= bus_ready_d;
      dmi_rdata_q <= dmi_rdata_d;
      bus_rdata_q <= bus_rdata_d;
      dmactive_q <= dmactive_d;
      ack_q <= ack_d;
      data_q <= data_d;
    end
  end
`ifdef DM_PROGBUF_INIT_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int j = 0; j < PROGBUF; j++) progbuf_q[j] <= (j == PROGBUF - 1) ? 32'h00100073 : 32'h00000013;
    end else begin
      progbuf_q <= progbuf_d;
    end
  end
`else
  always_ff @(posedge clk) begin
    progbuf_q <= progbuf_d;
  end
`endif
  assign dmi_ready = dmi_ready_q;
  assign bus_ready = bus_ready_q;
  assign dmi_rdata = dmi_rdata_q;
  assign bus_rdata = bus_rdata_q;
  assign debug_req = state_q == HALTING;
endmodule

// File: tb/tb_dm_hart_bridge.sv
// tb_dm_hart_bridge: directed checks of dm_hart_bridge with default parameters.
module tb_dm_hart_bridge;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic dmi_valid = 1'b0, dmi_write = 1'b0, bus_valid = 1'b0, bus_write = 1'b0;
  logic [6:0] dmi_addr = '0;
  logic [17:0] bus_addr = '0;
  logic [31:0] dmi_wdata = '0, bus_wdata = '0;
  logic dmi_ready, bus_ready, debug_req;
  logic [31:0] dmi_rdata, bus_rdata, r;
  int total = 0, bad = 0;

  dm_hart_bridge dut (
    .clk(clk), .resetn(resetn),
    .dmi_valid(dmi_valid), .dmi_ready(dmi_ready), .dmi_write(dmi_write),
    .dmi_addr(dmi_addr), .dmi_wdata(dmi_wdata), .dmi_rdata(dmi_rdata),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_write(bus_write),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .debug_req(debug_req)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic dmi_xfer(input logic w, input logic [6:0] a, input logic [31:0] d, output logic [31:0] rd);
    int n;
    @(negedge clk);
    dmi_valid = 1'b1; dmi_write = w; dmi_addr = a; dmi_wdata = d;
    n = 0;
    do begin @(negedge clk); n++; end while (dmi_ready !== 1'b1 && n < 20);
    chk("dmi_ready", {31'b0, dmi_ready}, 32'd1);
    rd = dmi_rdata;
    @(posedge clk); #1;
    dmi_valid = 1'b0;
  endtask

  task automatic bus_xfer(input logic w, input logic [17:0] a, input logic [31:0] d, output logic [31:0] rd);
    int n;
    @(negedge clk);
    bus_valid = 1'b1; bus_write = w; bus_addr = a; bus_wdata = d;
    n = 0;
    do begin @(negedge clk); n++; end while (bus_ready !== 1'b1 && n < 20);
    chk("bus_ready", {31'b0, bus_ready}, 32'd1);
    rd = bus_rdata;
    @(posedge clk); #1;
    bus_valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dmi_ready", {31'b0, dmi_ready}, 32'd0);
    chk("rst_bus_ready", {31'b0, bus_ready}, 32'd0);
    chk("rst_dmi_rdata", dmi_rdata, 32'd0);
    chk("rst_bus_rdata", bus_rdata, 32'd0);
    chk("rst_debug_req", {31'b0, debug_req}, 32'd0);
    @(negedge clk) resetn = 1'b1;
    dmi_xfer(0, 7'h11, 0, r); chk("rst_dmstatus", r, 32'h00000802);
    dmi_xfer(1, 7'h04, 32'hDEADBEEF, r);
    bus_xfer(0, 18'h40, 0, r); chk("bus_data0", r, 32'hDEADBEEF);
    dmi_xfer(1, 7'h05, 32'd5, r);
    dmi_xfer(0, 7'h05, 0, r); chk("dmi_data1", r, 32'd5);
    dmi_xfer(0, 7'h06, 0, r); chk("dmi_data_oor", r, 32'd0);
    bus_xfer(1, 18'h41, 32'h77, r);
    dmi_xfer(0, 7'h05, 0, r); chk("bus_wr_data1", r, 32'h77);
    dmi_xfer(1, 7'h10, 32'h1, r);
    dmi_xfer(0, 7'h10, 0, r); chk("dmcontrol_rd", r, 32'h1);
    dmi_xfer(1, 7'h10, 32'h80000001, r);
    chk("halt_debug_req", {31'b0, debug_req}, 32'd1);
    dmi_xfer(0, 7'h11, 0, r); chk("halting_status", r, 32'h00000002);
    bus_xfer(1, 18'h80, 32'h0, r);
    chk("halted_debug_req", {31'b0, debug_req}, 32'd0);
    dmi_xfer(0, 7'h11, 0, r); chk("halted_status", r, 32'h00000202);
    dmi_xfer(1, 7'h10, 32'hC0000001, r);
    bus_xfer(0, 18'h81, 0, r); chk("going", r, 32'd1);
    dmi_xfer(0, 7'h11, 0, r); chk("resuming_status", r, 32'h00000002);
    bus_xfer(1, 18'h82, 32'h0, r);
    dmi_xfer(0, 7'h11, 0, r); chk("resumed_status", r, 32'h00020802);
    bus_xfer(0, 18'h81, 0, r); chk("going_clr", r, 32'd0);
    // simultaneous progbuf[0] writes from both ports
    @(negedge clk);
    dmi_valid = 1; dmi_write = 1; dmi_addr = 7'h20; dmi_wdata = 32'h11111111;
    bus_valid = 1; bus_write = 1; bus_addr = 18'h0; bus_wdata = 32'h22222222;
    @(negedge clk);
    chk("coll_dmi_ready", {31'b0, dmi_ready}, 32'd1);
    chk("coll_bus_ready", {31'b0, bus_ready}, 32'd1);
    @(posedge clk); #1;
    dmi_valid = 0; bus_valid = 0;
    @(negedge clk);
    chk("coll_dmi_drop", {31'b0, dmi_ready}, 32'd0);
    chk("coll_bus_drop", {31'b0, bus_ready}, 32'd0);
    dmi_xfer(0, 7'h20, 0, r); chk("coll_dmi_pb0", r, 32'h11111111);
    bus_xfer(0, 18'h0, 0, r); chk("coll_bus_pb0", r, 32'h11111111);
    bus_xfer(1, 18'h90, 32'h5, r);
    bus_xfer(0, 18'h90, 0, r); chk("bus_unmapped", r, 32'd0);
    dmi_xfer(1, 7'h10, 32'h80000001, r);
    chk("halt2_debug_req", {31'b0, debug_req}, 32'd1);
    dmi_xfer(1, 7'h10, 32'h0, r);
    chk("deact_debug_req", {31'b0, debug_req}, 32'd0);
    dmi_xfer(0, 7'h11, 0, r); chk("deact_status", r, 32'h00020802);
    dmi_xfer(1, 7'h10, 32'h40000001, r);
    dmi_xfer(0, 7'h11, 0, r); chk("resume_in_run", r, 32'h00020802);
    // reset lands on the match edge of a progbuf write
    dmi_xfer(1, 7'h21, 32'hAAAA, r);
    @(negedge clk);
    dmi_valid = 1; dmi_write = 1; dmi_addr = 7'h21; dmi_wdata = 32'hBBBB;
    @(negedge clk) resetn = 1'b0;
    @(negedge clk) dmi_valid = 0;
    @(negedge clk) resetn = 1'b1;
    chk("rst_mid_ready", {31'b0, dmi_ready}, 32'd0);
    dmi_xfer(0, 7'h21, 0, r);
`ifdef DM_PROGBUF_INIT_EN
    chk("rst_mid_pb1", r, 32'h00000013);
    bus_xfer(0, 18'h6, 0, r); chk("init_pb6", r, 32'h00000013);
    bus_xfer(0, 18'h7, 0, r); chk("init_pb7", r, 32'h00100073);
`else
    chk("rst_mid_pb1", r, 32'h0000AAAA);
`endif
    dmi_xfer(0, 7'h04, 0, r); chk("rst_data0", r, 32'd0);
    // valid withdrawn before the match: ready pulses, no write
    @(negedge clk);
    dmi_valid = 1; dmi_write = 1; dmi_addr = 7'h05; dmi_wdata = 32'h99;
    @(negedge clk);
    chk("early_ready", {31'b0, dmi_ready}, 32'd1);
    dmi_valid = 0;
    @(negedge clk);
    chk("early_drop", {31'b0, dmi_ready}, 32'd0);
    dmi_xfer(0, 7'h05, 0, r); chk("early_nowrite", r, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dm_hart_bridge.md
# dm_hart_bridge

Parametrised debug-module core that joins the debug transport (DMI) to a single hart's debug-mode bus window. It holds the abstract data registers, the program buffer and the halt/resume control state machine. The external debugger reaches it over DMI; the hart executing debug-mode code in the debug ROM reaches it over a word-addressed system-bus port. It supersedes the fixed 8-word register/RAM debug block with configurable sizes and a real halt/resume handshake.

## Interface
- `DMI_ABITS`, default 7: DMI address width.
- `NDATA`, default 2, range 1..12: number of abstract `data` registers.
- `PROGBUF`, default 8, range 2..16: program-buffer depth in 32-bit words.
- `clk`  in  1  clock; all logic is on the rising edge.
- `resetn`  in  1  synchronous, active-low reset.
- `dmi_valid`  in  1  DMI request valid.
- `dmi_ready`  out  1  DMI request accepted this cycle.
- `dmi_write`  in  1  1 = write, 0 = read.
- `dmi_addr`  in  DMI_ABITS  DMI register address.
- `dmi_wdata`  in  32  DMI write data.
- `dmi_rdata`  out  32  DMI read data; valid while `dmi_ready`=1.
- `bus_valid`, `bus_ready`, `bus_write`  in/out/in  1  hart bus handshake, same rules as DMI.
- `bus_addr`  in  18  word address, bits [19:2].
- `bus_wdata`  in  32  hart write data.
- `bus_rdata`  out  32  hart read data; valid while `bus_ready`=1.
- `debug_req`  out  1  halt request to the hart.

## Operation
- **DMI map:**
  - 0x04+i: `data[i]`, read/write.
  - 0x10: `dmcontrol`. Bit31 = haltreq (write-1 pulse). Bit30 = resumereq (write-1 pulse). Bit0 = dmactive (stored). Reads return {0, dmactive}.
  - 0x11: `dmstatus`, read-only. Bit17 = allresumeack. Bit11 = allrunning. Bit9 = allhalted. Bits[3:0] = 2 (version).
  - 0x20+j: `progbuf[j]`, read/write.
  - Unmapped or out-of-range addresses: reads return 0; writes are ignored.
- **Bus map (word index):**
  - 0..PROGBUF-1: progbuf, read/write.
  - 0x40+i: `data[i]`, read/write.
  - 0x80 HALTED: a write of any value sets the halted state.
  - 0x81 GOING: reads return {31'b0, resume_pending}.
  - 0x82 RESUMING: a write of any value acknowledges the resume.
  - Any other address: reads return 0; writes are ignored.
- **Control FSM states:** RUNNING, HALTING, HALTED, RESUMING. Reset state is RUNNING.
  - RUNNING → HALTING: DMI write to `dmcontrol` with bit31=1.
  - HALTING → HALTED: bus write to HALTED.
  - HALTED → RESUMING: DMI write to `dmcontrol` with bit30=1. `resume_pending` is set and `allresumeack` is cleared.
  - RESUMING → RUNNING: bus write to RESUMING. `resume_pending` is cleared and `allresumeack` is set.
  - resumereq outside HALTED is ignored. haltreq outside RUNNING is ignored.
  - If haltreq and resumereq are both set in one write: in HALTED, resume wins; in RUNNING, halt wins.
- **Outputs derived from state:**
  - `debug_req` = 1 only in HALTING.
  - allhalted = HALTED.
  - allrunning = RUNNING.
- **dmactive=0:** the FSM is forced to RUNNING, `resume_pending`=0 and `debug_req`=0. Data registers and progbuf are unaffected.
- **Write collision:** if DMI and bus write the same progbuf or data word in the same cycle, the DMI write wins and the bus write is dropped. Both handshakes still complete.

## Timing
- **Handshake, both ports independently:**
  - `ready` rises the cycle after `valid` is seen high while `ready`=0.
  - `ready` drops the cycle after a match (`valid && ready`).
  - Minimum 2 cycles per transfer; back-to-back transfers therefore occur every 2 cycles.
- **Read data:** `rdata` is registered on the cycle `ready` rises, from the address presented that cycle. It holds until the next read.
- **Write effects:** a write takes effect on the match edge. It is visible to a read issued one cycle after the match. FSM transitions also occur on the match edge.
- **Early `valid` drop:** if `valid` falls before the match, `ready` still rises for one cycle and no write is performed.
- **Reset values:**
  - Outputs: `dmi_ready`=0, `bus_ready`=0, `dmi_rdata`=0, `bus_rdata`=0, `debug_req`=0.
  - Internal state: FSM=RUNNING, dmactive=0, allresumeack=0, `data[*]`=0.
- **Reset mid-transfer:** the transfer is abandoned and no write occurs on the reset edge.

## Configuration
- `DM_PROGBUF_INIT_EN` defined:
  - On reset, progbuf[0..PROGBUF-2] = 0x00000013 (nop) and progbuf[PROGBUF-1] = 0x00100073 (ebreak).
  - A hart entering the progbuf before the debugger writes it therefore returns straight to the debug ROM.
- `DM_PROGBUF_INIT_EN` undefined: progbuf has no reset; its contents are X until written.

## Test plan
- **Reset values:** after resetn low for 2 cycles, DMI read 0x11 → dmstatus = 0x00000802 (allrunning=1, version=2), `debug_req`=0.
- **Data registers, DMI then bus:** write 0x04 = 0xDEADBEEF, then bus read word 0x40 → 0xDEADBEEF. Write 0x05 = 5, then DMI read 0x05 → 5. With NDATA=2, a read of 0x06 → 0.
- **Halt/resume sequence:** with dmactive=1:
  - DMI write 0x10 = 0x80000001 → `debug_req`=1.
  - Bus write 0x80 → `debug_req`=0, dmstatus bit9=1.
  - DMI write 0x10 = 0x40000001 → bus read 0x81 = 1.
  - Bus write 0x82 → dmstatus = 0x00020802.
- **Progbuf collision:** DMI write 0x20 = 0x11111111 and bus write word 0 = 0x22222222 on the same edge → progbuf[0] = 0x11111111, and both `ready` signals pulse once.
- **Deactivation:** while HALTING, write dmcontrol = 0 → state RUNNING, `debug_req`=0 the next cycle, dmstatus bit11=1.
- **`DM_PROGBUF_INIT_EN`:** with the macro defined and PROGBUF=8, after reset bus read word 6 → 0x00000013 and word 7 → 0x00100073.
